// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: funct3 sizes, FSM state codes,
// byte-enable patterns and the store-side lane helpers.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Unsigned size variants share the lane pattern of their signed twins.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: byte_enables = BE_B << off;
      F3_H, F3_HU: byte_enables = BE_H << {off[1], 1'b0};
      default:     byte_enables = BE_W;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      F3_B, F3_BU: store_lanes = {4{rs2[7:0]}};
      F3_H, F3_HU: store_lanes = {2{rs2[15:0]}};
      default:     store_lanes = rs2;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load-lane extraction: picks the byte/halfword addressed by the latched offset
// and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection from the read word.
  always_comb begin
    byte_s = rdata[7:0];
    case (offset)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (offset[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension by access size and signedness.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_BU:   result = {24'd0, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_HU:   result = {16'd0, half_s};
      F3_W:    result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns execute-stage loads/stores into req/ack bus
// transactions and stalls until done. Optional trap: MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_MemRead,
  input  logic              ex_MemWrite,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_Addr,
  input  logic [31:0]       ex_StoreData,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ld_data,
  output logic              misalign
);

  state_t      state_r;
  logic [2:0]  funct3_r;
  logic [1:0]  offset_r;
  logic        access_s;
  logic        misalign_det_s;
  logic [31:0] ext_s;

  assign access_s = ex_valid & (ex_MemRead | ex_MemWrite);

`ifdef MISALIGN_TRAP_EN
  // Halfwords need an even address, words (and unlisted sizes) a word-aligned one.
  always_comb begin
    misalign_det_s = 1'b0;
    case (ex_funct3)
      F3_B, F3_BU: misalign_det_s = 1'b0;
      F3_H, F3_HU: misalign_det_s = ex_Addr[0];
      default:     misalign_det_s = |ex_Addr[1:0];
    endcase
  end
`else
  assign misalign_det_s = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .offset (offset_r),
    .funct3 (funct3_r),
    .result (ext_s)
  );

  // Stall: detect cycle in IDLE plus every BUSY cycle; never during reset.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      stall = 1'b0;
    end else if (state_r == ST_BUSY) begin
      stall = 1'b1;
    end else if (state_r == ST_IDLE) begin
      stall = access_s;
    end else begin
      stall = 1'b0;
    end
  end

  // Transaction FSM with registered bus outputs and load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      funct3_r  <= 3'd0;
      offset_r  <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      ld_data   <= 32'd0;
      misalign  <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (access_s && misalign_det_s) begin
            misalign <= 1'b1;
            state_r  <= ST_DONE;
          end else if (access_s) begin
            funct3_r  <= ex_funct3;
            offset_r  <= ex_Addr[1:0];
            mem_we    <= ex_MemWrite;
            mem_addr  <= {ex_Addr[ADDR_W-1:2], 2'b00};
            mem_be    <= byte_enables(ex_funct3, ex_Addr[1:0]);
            mem_wdata <= store_lanes(ex_funct3, ex_StoreData);
            mem_req   <= 1'b1;
            state_r   <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              ld_data <= ext_s;
            end else begin
              ld_data <= ld_data;
            end
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        // The stalled instruction is still on ex_*; it must not retrigger.
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage RISC-V pipeline, between execute and the memory/writeback register stage. Turns an execute-stage load/store into a request/acknowledge transaction on the data-memory bus. Generates byte enables and store-lane replication, stalls the pipeline until the bus acknowledges, and returns an aligned, sign- or zero-extended load word for the downstream stage to register.

## Interface
- ADDR_W, 32, address width; data is fixed at 32 bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low: 0 = reset.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_MemRead / ex_MemWrite  in  1 each  load / store request; both high = store.
- ex_funct3  in  3  RV32I size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- ex_Addr  in  ADDR_W  byte address (ALU result).
- ex_StoreData  in  32  rs2 value.
- stall  out  1  freezes upstream stages and deasserts downstream EN.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  one-cycle completion strobe.
- mem_rdata  in  32  read word, valid with mem_ack.
- ld_data  out  32  extended load result, registered.
- misalign  out  1  one-cycle trap pulse; tied 0 without MISALIGN_TRAP_EN.

## Operation
- FSM states IDLE, BUSY, DONE.
- access = ex_valid & (ex_MemRead | ex_MemWrite).
- IDLE:
  - access: latch mem_addr, mem_be, mem_wdata, mem_we, funct3 and byte offset; set mem_req=1; go to BUSY.
  - No access: stay in IDLE.
- BUSY: hold every bus output stable. On mem_ack: mem_req=0; for loads, ld_data ← extend(mem_rdata); go to DONE.
- DONE: ignore ex_* inputs, because the stalled instruction is still presented. Go to IDLE unconditionally.
- stall = (IDLE & access) | BUSY. stall is 0 in DONE and while reset is low.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << {addr[1],0}.
  - W: 1111.
  - Loads drive the same byte-enable pattern.
- Store data: B = {4{rs2[7:0]}}, H = {2{rs2[15:0]}}, W = rs2.
- Load extraction selects the lane by the latched offset:
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- Unlisted funct3 values are treated as W.
- Stores leave ld_data unchanged. mem_ack is ignored outside BUSY.
- Reset values: mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_data and misalign are all 0; state is IDLE.
- Reset during BUSY abandons the transaction: mem_req drops asynchronously, and the bus must tolerate this.

## Timing
- Minimum memory-instruction occupancy is 3 cycles: IDLE-detect (stall), BUSY with ack (stall), DONE (no stall). This is 2 stall cycles.
- Each extra BUSY cycle without ack adds one stall cycle. There is no timeout.
- ld_data is valid from the DONE cycle onward; downstream captures it at the end of DONE.
- Non-memory instructions pass with zero stall.
- Back-to-back memory instructions: the second is detected in the cycle after DONE.
- mem_req rises one cycle after detection. Ack is allowed in the first BUSY cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misalignment is H with addr[0]=1, or W with addr[1:0]≠0.
  - A misaligned access goes IDLE→DONE without raising mem_req.
  - misalign=1 during DONE; ld_data is unchanged; stall is 1 for the detect cycle only.
- MISALIGN_TRAP_EN undefined: misalign is tied 0 and offset bits are truncated. H uses addr[1] only; W ignores addr[1:0].

## Structure
- Package mem_access_pkg holds:
  - funct3 size encodings.
  - the state enum (IDLE/BUSY/DONE).
  - byte-enable constants.
- One combinational sub-module, load_extend: inputs rdata, offset and funct3; output 32-bit result.

## Test plan
- Reset: assert reset=0 mid-BUSY → mem_req=0 immediately; state IDLE; ld_data=0; stall=0.
- LB at 0x1003 with mem_rdata=0x80_00_00_00 and ack in the first BUSY cycle:
  - mem_addr=0x1000, mem_be=1000.
  - ld_data=0xFFFFFF80; stall high for exactly 2 cycles.
- LHU at 0x2002 with rdata=0xBEEF1234 → ld_data=0x0000BEEF, mem_be=1100.
- SB rs2=0x000000A5 at 0x3001 with ack after 3 wait cycles:
  - mem_we=1, mem_be=0010, mem_wdata=0xA5A5A5A5.
  - Bus outputs stable throughout; stall 5 cycles.
- Back-to-back: SW then LW, each with ack in the first BUSY cycle → second request starts the cycle after the first DONE; no duplicate request for either.
- Misaligned LW at 0x4002:
  - With MISALIGN_TRAP_EN: no mem_req; misalign pulses once; stall 1 cycle.
  - Without it: mem_addr=0x4000, mem_be=1111.
